// File: rtl/kernel_nco_sweep_ctrl_if.sv
// rtl/kernel_nco_sweep_ctrl_if.sv - Avalon-MM register bus for the NCO sweep controller
interface kernel_nco_sweep_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/kernel_nco_sweep_ctrl.sv
// rtl/kernel_nco_sweep_ctrl.sv - register-programmed linear phase-increment sweep for an NCO
module kernel_nco_sweep_ctrl #(
  parameter int DWELL_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  kernel_nco_sweep_ctrl_if.slave bus,
  output logic [31:0]            out_port,
  output logic                   busy,
  output logic                   irq
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state_q, state_d;
  logic [31:0]            start_r, stop_r, step_r;
  logic [DWELL_WIDTH-1:0] dwell_r;
  logic                   loop_r, ie_r, done_r;
  logic [31:0]            w_start, w_stop, w_step;
  logic [DWELL_WIDTH-1:0] w_dwell, cnt_q;
  logic                   wr, ctrl_wr, go, abort, preset, status_clr;
  logic [32:0]            next_sum;
  logic [31:0]            next_val;
  logic                   capture, do_preset, do_wrap, do_step, cnt_dec, done_set;
  logic [31:0]            dwell_rd;

  function automatic logic [DWELL_WIDTH-1:0] reload(input logic [DWELL_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - DWELL_WIDTH'(1);
  endfunction

  assign wr         = bus.chipselect & ~bus.write_n;
  assign ctrl_wr    = wr & (bus.address == 3'd4);
  assign go         = ctrl_wr & bus.writedata[0];
  assign abort      = ctrl_wr & bus.writedata[1];
  assign preset     = ctrl_wr & bus.writedata[3];
  assign status_clr = wr & (bus.address == 3'd5) & bus.writedata[1];

  // 33-bit compare also catches the wrap: a carry means the sum exceeds any STOP.
  assign next_sum = {1'b0, out_port} + {1'b0, w_step};
  assign next_val = (next_sum >= {1'b0, w_stop}) ? w_stop : next_sum[31:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    do_preset = 1'b0;
    do_wrap   = 1'b0;
    do_step   = 1'b0;
    cnt_dec   = 1'b0;
    done_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (go) begin
          capture = 1'b1;
          state_d = RUN;
        end else if (preset) begin
          do_preset = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_dec = 1'b1;
        end else if (out_port == w_stop) begin
          if (loop_r) begin
            do_wrap = 1'b1;
          end else begin
            state_d  = IDLE;
            done_set = 1'b1;
          end
        end else begin
          do_step = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_r  <= '0;
      stop_r   <= '0;
      step_r   <= '0;
      dwell_r  <= '0;
      loop_r   <= 1'b0;
      ie_r     <= 1'b0;
      done_r   <= 1'b0;
      w_start  <= '0;
      w_stop   <= '0;
      w_step   <= '0;
      w_dwell  <= '0;
      cnt_q    <= '0;
      out_port <= '0;
    end else begin
      if (wr) begin
        case (bus.address)
          3'd0: start_r <= bus.writedata;
          3'd1: stop_r  <= bus.writedata;
          3'd2: step_r  <= bus.writedata;
          3'd3: dwell_r <= bus.writedata[DWELL_WIDTH-1:0];
          3'd4: begin
            loop_r <= bus.writedata[2];
            ie_r   <= bus.writedata[4];
          end
          default: ;
        endcase
      end

      if (done_set)        done_r <= 1'b1;
      else if (status_clr) done_r <= 1'b0;

      if (capture) begin
        w_start  <= start_r;
        w_stop   <= stop_r;
        w_step   <= step_r;
        w_dwell  <= dwell_r;
        out_port <= start_r;
        cnt_q    <= reload(dwell_r);
      end else if (do_preset) begin
        out_port <= start_r;
      end else if (do_wrap) begin
        out_port <= w_start;
        cnt_q    <= reload(w_dwell);
      end else if (do_step) begin
        out_port <= next_val;
        cnt_q    <= reload(w_dwell);
      end else if (cnt_dec) begin
        cnt_q <= cnt_q - DWELL_WIDTH'(1);
      end
    end
  end

  always_comb begin
    dwell_rd                   = '0;
    dwell_rd[DWELL_WIDTH-1:0]  = dwell_r;
  end

  always_comb begin
    bus.readdata = '0;
    case (bus.address)
      3'd0: bus.readdata = start_r;
      3'd1: bus.readdata = stop_r;
      3'd2: bus.readdata = step_r;
      3'd3: bus.readdata = dwell_rd;
      3'd4: bus.readdata = {27'b0, ie_r, 1'b0, loop_r, 2'b0};
      3'd5: bus.readdata = {30'b0, done_r, busy};
      3'd6: bus.readdata = out_port;
      default: bus.readdata = '0;
    endcase
  end

  assign busy = (state_q == RUN);
  assign irq  = done_r & ie_r;

endmodule

// File: tb/tb_kernel_nco_sweep_ctrl.sv
// tb/tb_kernel_nco_sweep_ctrl.sv - self-checking bench for kernel_nco_sweep_ctrl
module tb_kernel_nco_sweep_ctrl;

  logic        clk;
  logic        reset_n;
  logic [31:0] out_port;
  logic        busy;
  logic        irq;

  kernel_nco_sweep_ctrl_if bus_if ();

  kernel_nco_sweep_ctrl #(.DWELL_WIDTH(24)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus_if),
    .out_port (out_port),
    .busy     (busy),
    .irq      (irq)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] rd;
  logic [31:0] disturbed_start;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_if.address = a;
    #1;
    d = bus_if.readdata;
  endtask

  // Expected out_port trace: every phase value repeated max(dwell,1) times, clamped at STOP.
  task automatic build_trace(input logic [31:0] start, input logic [31:0] stop,
                             input logic [31:0] step, input logic [31:0] dwell);
    logic [31:0] v;
    logic [32:0] nx;
    int          hold;
    exp_q.delete();
    hold = (dwell[23:0] == 0) ? 1 : int'(dwell[23:0]);
    v = start;
    forever begin
      for (int k = 0; k < hold; k++) exp_q.push_back(v);
      if (v == stop) break;
      nx = {1'b0, v} + {1'b0, step};
      if (nx > {1'b0, 32'hFFFF_FFFF} || nx[31:0] >= stop) v = stop;
      else                                                 v = nx[31:0];
    end
  endtask

  task automatic run_sweep(input logic [31:0] start, input logic [31:0] stop,
                           input logic [31:0] step, input logic [31:0] dwell,
                           input logic [31:0] ctrl, input bit disturb);
    logic [31:0] r;
    bus_write(3'd0, start);
    bus_write(3'd1, stop);
    bus_write(3'd2, step);
    bus_write(3'd3, dwell);
    bus_write(3'd5, 32'h2);
    build_trace(start, stop, step, dwell);
    bus_write(3'd4, ctrl | 32'h1);
    foreach (exp_q[i]) begin
      @(negedge clk);
      check("trace_out", out_port, exp_q[i]);
      check("trace_busy", 32'(busy), 32'd1);
      if (disturb && i == 0) begin
        disturbed_start   = $urandom;
        bus_if.address    = 3'd0;
        bus_if.writedata  = disturbed_start;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
      end else begin
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
      end
    end
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    check("end_busy", 32'(busy), 32'd0);
    check("end_out", out_port, stop);
    bus_read(3'd5, r);
    check("end_status", r, 32'h2);
    bus_read(3'd6, r);
    check("end_current", r, stop);
    check("end_irq", 32'(irq), 32'(ctrl[4]));
  endtask

  initial begin
    logic [31:0] s, e, st, dw, rng;
    bus_if.address    = '0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    reset_n           = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    check("rst_out", out_port, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check("rst_reg", rd, 32'd0);
    end
    repeat (4) @(negedge clk);
    check("idle_after_rst", 32'(busy), 32'd0);

    bus_write(3'd3, 32'hFFFF_FFFF);
    bus_read(3'd3, rd);
    check("dwell_mask", rd, 32'h00FF_FFFF);
    bus_read(3'd7, rd);
    check("addr7_zero", rd, 32'd0);

    run_sweep(32'd100, 32'd130, 32'd10, 32'd3, 32'h0, 1'b0);
    run_sweep(32'd100, 32'd125, 32'd10, 32'd3, 32'h0, 1'b0);
    run_sweep(32'd5, 32'd7, 32'd1, 32'd0, 32'h0, 1'b0);
    run_sweep(32'd50, 32'd20, 32'd4, 32'd2, 32'h0, 1'b0);
    run_sweep(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h20, 32'd2, 32'h0, 1'b0);

    // Loop sweep 0,1,2,0,1 then abort while value 1 is showing.
    bus_write(3'd0, 32'd0);
    bus_write(3'd1, 32'd2);
    bus_write(3'd2, 32'd1);
    bus_write(3'd3, 32'd1);
    bus_write(3'd5, 32'h2);
    bus_write(3'd4, 32'h4);
    bus_write(3'd4, 32'h5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("loop_out", out_port, 32'(i % 3));
    end
    bus_if.address    = 3'd4;
    bus_if.writedata  = 32'h2;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_out", out_port, 32'd1);
    bus_read(3'd5, rd);
    check("abort_status", rd, 32'd0);

    run_sweep(32'd3, 32'd3, 32'd1, 32'd2, 32'h10, 1'b0);
    bus_read(3'd4, rd);
    check("ctrl_read", rd, 32'h10);
    bus_write(3'd5, 32'h1);
    bus_read(3'd5, rd);
    check("status_bit0_noop", rd, 32'h2);
    bus_write(3'd5, 32'h2);
    @(negedge clk);
    check("clr_irq", 32'(irq), 32'd0);
    bus_read(3'd5, rd);
    check("clr_status", rd, 32'd0);
    bus_write(3'd4, 32'h13);
    repeat (3) @(negedge clk);
    check("go_abort_busy", 32'(busy), 32'd0);
    check("go_abort_out", out_port, 32'd3);

    // Random sweeps, each with a START rewrite mid-run that only a later preset exposes.
    for (int n = 0; n < 16; n++) begin
      s   = $urandom_range(1000, 32'h7FFF_FFFF);
      rng = $urandom_range(0, 200);
      e   = ($urandom_range(0, 4) == 0) ? s - rng : s + rng;
      st  = $urandom_range(1, 220);
      dw  = $urandom_range(0, 4);
      run_sweep(s, e, st, dw, 32'h0, 1'b1);
      bus_write(3'd4, 32'h8);
      @(negedge clk);
      check("preset_out", out_port, disturbed_start);
      check("preset_busy", 32'(busy), 32'd0);
    end

    // Endless STEP=0 sweep cut by asynchronous reset.
    bus_write(3'd0, 32'd5);
    bus_write(3'd1, 32'd9);
    bus_write(3'd2, 32'd0);
    bus_write(3'd3, 32'd1);
    bus_write(3'd4, 32'h1);
    repeat (20) @(negedge clk);
    check("step0_busy", 32'(busy), 32'd1);
    check("step0_out", out_port, 32'd5);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_out", out_port, 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      bus_read(3'(a), rd);
      check("rst2_reg", rd, 32'd0);
    end
    repeat (5) @(negedge clk);
    check("rst2_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
